// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin front end that shares one 16-to-1 serializer
// between NUM_REQ requesters. It latches the winning word, runs the
// start / data_loaded / data_sent handshake and pulses ack to the winner.
// Optional macro SER_TIMEOUT_EN adds a per-transfer watchdog (TIMEOUT_CYCLES)
// that aborts a stuck transfer with a timeout_err pulse.
//
// state | meaning
// IDLE  | no transfer; pick a round-robin winner when any req is set
// LOAD  | ser_start held high until the serializer reports data_loaded
// SEND  | waiting for data_sent; ack the granted requester on it
// DRAIN | waiting for data_sent to drop before the next grant

module serializer_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic [GW-1:0]             grant_id,
   output logic [DATA_W-1:0]         ser_data,
   output logic                      ser_start,
   input  logic                      ser_data_loaded,
   input  logic                      ser_data_sent,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [GW-1:0]        last_grant, last_nxt;
   logic [GW-1:0]        winner, cand;
   logic                 found;
   logic [GW-1:0]        gid_nxt;
   logic [DATA_W-1:0]    data_nxt;
   logic                 start_nxt;
   logic [NUM_REQ-1:0]   ack_nxt;

`ifdef SER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          terr_nxt;

   // Watchdog down-counter: preloaded while idle, runs through LOAD and SEND.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tmo_cnt <= CW'(TIMEOUT_CYCLES - 1);
      end else if (state == ST_IDLE) begin
         tmo_cnt <= CW'(TIMEOUT_CYCLES - 1);
      end else if ((state == ST_LOAD || state == ST_SEND) && tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo_hit = (tmo_cnt == '0);

   // Abort pulse is registered so it lines up with the DRAIN entry.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= terr_nxt;
      end
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
   assign timeout_err    = 1'b0;
`endif

   // Round-robin scan starting just after the last served requester.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Next-state and next-output logic for the handshake sequencer.
   always_comb begin
      state_nxt = state;
      last_nxt  = last_grant;
      gid_nxt   = grant_id;
      data_nxt  = ser_data;
      start_nxt = ser_start;
      ack_nxt   = '0;
`ifdef SER_TIMEOUT_EN
      terr_nxt  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_nxt = ST_LOAD;
               gid_nxt   = winner;
               data_nxt  = req_data[int'(winner)*DATA_W +: DATA_W];
               start_nxt = 1'b1;
            end
         end
         ST_LOAD: begin
            // data_loaded has priority; a coincident data_sent is seen in SEND.
            if (ser_data_loaded) begin
               state_nxt = ST_SEND;
               start_nxt = 1'b0;
            end
`ifdef SER_TIMEOUT_EN
            else if (tmo_hit) begin
               state_nxt = ST_DRAIN;
               start_nxt = 1'b0;
               terr_nxt  = 1'b1;
               last_nxt  = grant_id;
            end
`endif
         end
         ST_SEND: begin
            if (ser_data_sent) begin
               state_nxt         = ST_DRAIN;
               ack_nxt[grant_id] = 1'b1;
               last_nxt          = grant_id;
            end
`ifdef SER_TIMEOUT_EN
            else if (tmo_hit) begin
               state_nxt = ST_DRAIN;
               terr_nxt  = 1'b1;
               last_nxt  = grant_id;
            end
`endif
         end
         ST_DRAIN: begin
            if (!ser_data_sent) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered outputs and round-robin pointer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_grant <= GW'(NUM_REQ - 1);
         grant_id   <= '0;
         ser_data   <= '0;
         ser_start  <= 1'b0;
         ack        <= '0;
      end else begin
         last_grant <= last_nxt;
         grant_id   <= gid_nxt;
         ser_data   <= data_nxt;
         ser_start  <= start_nxt;
         ack        <= ack_nxt;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter: vector table for round-robin rotation
// plus hand sequences for latching, fairness, mid-transfer reset and watchdog.
module tb_serializer_arbiter;

   logic        clock;
   logic        resetn;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [3:0]  ack;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] ser_data;
   logic        ser_start;
   logic        ser_data_loaded;
   logic        ser_data_sent;
   logic        timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  req;
      logic        ld;
      logic        snt;
      logic [3:0]  e_ack;
      logic        e_busy;
      logic [1:0]  e_gid;
      logic [15:0] e_data;
      logic        e_start;
   } vec_t;

   vec_t vt[$];

   serializer_arbiter #(
      .NUM_REQ(4),
      .DATA_W(16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .req(req),
      .req_data(req_data),
      .ack(ack),
      .busy(busy),
      .grant_id(grant_id),
      .ser_data(ser_data),
      .ser_start(ser_start),
      .ser_data_loaded(ser_data_loaded),
      .ser_data_sent(ser_data_sent),
      .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] e_ack, input logic e_busy,
                      input logic [1:0] e_gid, input logic [15:0] e_data, input logic e_start);
      n_tests++;
      if (ack !== e_ack || busy !== e_busy || grant_id !== e_gid || ser_data !== e_data ||
          ser_start !== e_start || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got ack=%b busy=%b gid=%0d data=%h start=%b terr=%b, want ack=%b busy=%b gid=%0d data=%h start=%b terr=0",
                  name, ack, busy, grant_id, ser_data, ser_start, timeout_err,
                  e_ack, e_busy, e_gid, e_data, e_start);
      end
   endtask

   task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic add_vec(input logic [3:0] r, input logic ld, input logic snt,
                          input logic [3:0] e_ack, input logic e_busy, input logic [1:0] e_gid,
                          input logic [15:0] e_data, input logic e_start);
      vec_t v;
      v.req = r; v.ld = ld; v.snt = snt;
      v.e_ack = e_ack; v.e_busy = e_busy; v.e_gid = e_gid; v.e_data = e_data; v.e_start = e_start;
      vt.push_back(v);
   endtask

   // Full handshake for one grant with checks at grant, ack and return to idle.
   task automatic xfer(input logic [3:0] r, input logic [1:0] eg, input logic [15:0] ed);
      req = r;
      step();
      chk("xfer_grant", 4'b0000, 1'b1, eg, ed, 1'b1);
      ser_data_loaded = 1'b1;
      step();
      ser_data_loaded = 1'b0;
      ser_data_sent   = 1'b1;
      step();
      chk("xfer_ack", 4'b0001 << eg, 1'b1, eg, ed, 1'b0);
      ser_data_sent = 1'b0;
      req           = 4'b0000;
      step();
      chk("xfer_idle", 4'b0000, 1'b0, eg, ed, 1'b0);
   endtask

   initial begin
      logic [1:0]  gseq [5];
      logic [15:0] words [4];
      int          start_cnt;
      logic        saw_ack;

      gseq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

      // Rotation with all four requests held; the last transfer has
      // data_loaded and data_sent together in LOAD.
      for (int t = 0; t < 5; t++) begin
         add_vec(4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, gseq[t], words[gseq[t]], 1'b1);
         if (t == 4) begin
            add_vec(4'hF, 1'b1, 1'b1, 4'b0000, 1'b1, gseq[t], words[gseq[t]], 1'b0);
         end else begin
            add_vec(4'hF, 1'b1, 1'b0, 4'b0000, 1'b1, gseq[t], words[gseq[t]], 1'b0);
         end
         add_vec(4'hF, 1'b0, 1'b1, 4'b0001 << gseq[t], 1'b1, gseq[t], words[gseq[t]], 1'b0);
         add_vec(4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, gseq[t], words[gseq[t]], 1'b0);
      end

      resetn          = 1'b0;
      req             = 4'b0000;
      req_data        = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      ser_data_loaded = 1'b0;
      ser_data_sent   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset", 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0);
      @(negedge clock);
      resetn = 1'b1;
      step();
      chk("idle_after_reset", 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0);

      for (int i = 0; i < vt.size(); i++) begin
         req             = vt[i].req;
         ser_data_loaded = vt[i].ld;
         ser_data_sent   = vt[i].snt;
         step();
         chk($sformatf("rot_vec%0d", i), vt[i].e_ack, vt[i].e_busy, vt[i].e_gid,
             vt[i].e_data, vt[i].e_start);
      end
      req             = 4'b0000;
      ser_data_loaded = 1'b0;
      ser_data_sent   = 1'b0;
      step();

      // Single transfer: word latched at grant, later req/req_data changes ignored.
      req_data[15:0] = 16'hF0F0;
      req            = 4'b0001;
      step();
      chk("single_grant", 4'b0000, 1'b1, 2'd0, 16'hF0F0, 1'b1);
      start_cnt = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         if (ser_start === 1'b1) start_cnt++;
      end
      ser_data_loaded = 1'b1;
      req_data[15:0]  = 16'h0000;
      req             = 4'b0000;
      step();
      ser_data_loaded = 1'b0;
      chk1("single_start_cycles", start_cnt, 3);
      chk("single_loaded", 4'b0000, 1'b1, 2'd0, 16'hF0F0, 1'b0);
      saw_ack = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack !== 4'b0000) saw_ack = 1'b1;
      end
      chk1("single_no_early_ack", saw_ack, 0);
      chk("single_sending", 4'b0000, 1'b1, 2'd0, 16'hF0F0, 1'b0);
      ser_data_sent = 1'b1;
      step();
      chk("single_ack", 4'b0001, 1'b1, 2'd0, 16'hF0F0, 1'b0);
      step();
      chk("single_drain", 4'b0000, 1'b1, 2'd0, 16'hF0F0, 1'b0);
      ser_data_sent = 1'b0;
      step();
      chk("single_idle", 4'b0000, 1'b0, 2'd0, 16'hF0F0, 1'b0);
      req_data[15:0] = 16'h1111;

      // Fairness: after serving 2, {0,2} requesting goes to 0 then 2.
      xfer(4'b0100, 2'd2, 16'h3333);
      xfer(4'b0101, 2'd0, 16'h1111);
      xfer(4'b0101, 2'd2, 16'h3333);

      // Reset while in SEND: outputs clear at once and priority restarts at 0.
      req = 4'b0010;
      step();
      chk("rst_grant", 4'b0000, 1'b1, 2'd1, 16'h2222, 1'b1);
      ser_data_loaded = 1'b1;
      step();
      ser_data_loaded = 1'b0;
      step();
      chk("rst_in_send", 4'b0000, 1'b1, 2'd1, 16'h2222, 1'b0);
      #2;
      resetn = 1'b0;
      req    = 4'b0000;
      #1;
      chk("rst_async", 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0);
      @(negedge clock);
      resetn = 1'b1;
      step();
      chk("rst_no_ack", 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0);
      xfer(4'hF, 2'd0, 16'h1111);

`ifdef SER_TIMEOUT_EN
      begin
         int  edges;
         logic hit;
         req = 4'b0110;
         step();
         chk("tmo_grant", 4'b0000, 1'b1, 2'd1, 16'h2222, 1'b1);
         edges   = 0;
         hit     = 1'b0;
         saw_ack = 1'b0;
         for (int i = 0; i < 20 && !hit; i++) begin
            step();
            edges++;
            if (ack !== 4'b0000) saw_ack = 1'b1;
            if (timeout_err === 1'b1) hit = 1'b1;
         end
         chk1("tmo_seen", hit, 1);
         chk1("tmo_cycles", edges, 8);
         chk1("tmo_no_ack", saw_ack, 0);
         chk1("tmo_start_low", ser_start, 0);
         step();
         chk1("tmo_pulse_len", timeout_err, 0);
         chk1("tmo_idle", busy, 0);
         xfer(4'b0110, 2'd2, 16'h3333);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
